// File: rtl/warp_pkg.sv
// Shared types and default sizes for the Warp SIMT engine.
// No ports. Provides NUM_WARPS_DEFAULT, NUM_LANES_DEFAULT, INSTR_WIDTH,
// FIFO_DEPTH, warp_id_t and warp_issue_t (the payload held in a warp FIFO
// entry and in the issue register).
package warp_pkg;

   localparam int NUM_WARPS_DEFAULT = 4;
   localparam int NUM_LANES_DEFAULT = 8;
   localparam int INSTR_WIDTH       = 32;
   localparam int FIFO_DEPTH        = 4;

   typedef logic [$clog2(NUM_WARPS_DEFAULT)-1:0] warp_id_t;

   typedef struct packed {
      warp_id_t                      warp_id;
      logic [INSTR_WIDTH-1:0]        instr;
      logic [NUM_LANES_DEFAULT-1:0]  mask;
   } warp_issue_t;

endpackage

// File: rtl/warp_fifo.sv
// Synchronous FIFO, one per warp context.
// Ports: clk, rst (async, active-high), wr_en/wr_data (write ignored when full),
// rd_en (pop, ignored when empty), rd_data (head entry, combinational),
// full, empty.
// Pointers carry an extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module warp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp issue scheduler: per-warp instruction FIFOs, per-warp in-flight
// tracking, and a round-robin arbiter feeding one registered issue port.
// Ports:
//   clk, rst (async, active-high)
//   cmd_valid/cmd_ready/cmd_warp_id/cmd_instr/cmd_mask   enqueue side
//   warp_enable                                         per-warp issue enable
//   issue_valid/issue_ready/issue_warp_id/issue_instr/issue_mask  issue side
//   done_valid/done_warp_id                             completions
//   warp_pending, busy, err_orphan_done                 status
// Optional: define WARP_SCHED_PERF_EN to add perf_issued and perf_stall
// (32-bit wrapping counters of issue handshakes and stalled cycles).
module warp_scheduler
   import warp_pkg::*;
#(
   parameter int NUM_WARPS   = NUM_WARPS_DEFAULT,
   parameter int NUM_LANES   = NUM_LANES_DEFAULT,
   parameter int INSTR_WIDTH = warp_pkg::INSTR_WIDTH,
   parameter int FIFO_DEPTH  = warp_pkg::FIFO_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [$clog2(NUM_WARPS)-1:0] cmd_warp_id,
   input  logic [INSTR_WIDTH-1:0]       cmd_instr,
   input  logic [NUM_LANES-1:0]         cmd_mask,
   input  logic [NUM_WARPS-1:0]         warp_enable,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [$clog2(NUM_WARPS)-1:0] issue_warp_id,
   output logic [INSTR_WIDTH-1:0]       issue_instr,
   output logic [NUM_LANES-1:0]         issue_mask,
   input  logic                         done_valid,
   input  logic [$clog2(NUM_WARPS)-1:0] done_warp_id,
   output logic [NUM_WARPS-1:0]         warp_pending,
   output logic                         busy,
`ifdef WARP_SCHED_PERF_EN
   output logic [31:0]                  perf_issued,
   output logic [31:0]                  perf_stall,
`endif
   output logic                         err_orphan_done
);

   localparam int WW = $clog2(NUM_WARPS);

   // Same layout as warp_issue_t, sized by this instance's parameters.
   typedef struct packed {
      logic [WW-1:0]          warp_id;
      logic [INSTR_WIDTH-1:0] instr;
      logic [NUM_LANES-1:0]   mask;
   } issue_t;

   localparam int EW = $bits(issue_t);

   logic [NUM_WARPS-1:0] fifo_full;
   logic [NUM_WARPS-1:0] fifo_empty;
   logic [NUM_WARPS-1:0] fifo_wr;
   logic [NUM_WARPS-1:0] fifo_rd;
   logic [EW-1:0]        fifo_head [NUM_WARPS];
   logic [NUM_WARPS-1:0] inflight;
   logic [NUM_WARPS-1:0] eligible;
   logic [WW-1:0]        last_grant;
   logic [WW-1:0]        grant_id;
   logic                 grant_found;
   logic                 load;
   issue_t               cmd_entry;
   issue_t               issue_reg;

   assign cmd_ready = !fifo_full[cmd_warp_id];
   assign cmd_entry = '{warp_id: cmd_warp_id, instr: cmd_instr, mask: cmd_mask};

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      assign fifo_wr[w] = cmd_valid && cmd_ready && (cmd_warp_id == WW'(w));
      assign fifo_rd[w] = load && (grant_id == WW'(w));

      warp_fifo #(
         .WIDTH (EW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (fifo_wr[w]),
         .wr_data (cmd_entry),
         .rd_en   (fifo_rd[w]),
         .rd_data (fifo_head[w]),
         .full    (fifo_full[w]),
         .empty   (fifo_empty[w])
      );
   end

   assign eligible = warp_enable & ~fifo_empty & ~inflight;

   // Round-robin search from last_grant+1; WW-bit addition wraps modulo
   // NUM_WARPS, and i == NUM_WARPS revisits last_grant itself.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         if (!grant_found && eligible[WW'(last_grant + WW'(i))]) begin
            grant_found = 1'b1;
            grant_id    = WW'(last_grant + WW'(i));
         end
      end
   end

   assign load = grant_found && (!issue_valid || issue_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid <= 1'b0;
         issue_reg   <= '0;
         last_grant  <= WW'(NUM_WARPS - 1);
      end else if (load) begin
         issue_valid <= 1'b1;
         issue_reg   <= issue_t'(fifo_head[grant_id]);
         last_grant  <= grant_id;
      end else if (issue_ready) begin
         issue_valid <= 1'b0;
      end
   end

   // A warp being loaded is never in flight, so a same-edge done for it can
   // only be an orphan; letting the set win keeps the new issue tracked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight        <= '0;
         err_orphan_done <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (load && (grant_id == WW'(w)))
               inflight[w] <= 1'b1;
            else if (done_valid && (done_warp_id == WW'(w)))
               inflight[w] <= 1'b0;
         end
         if (done_valid && !inflight[done_warp_id])
            err_orphan_done <= 1'b1;
      end
   end

   assign issue_warp_id = issue_reg.warp_id;
   assign issue_instr   = issue_reg.instr;
   assign issue_mask    = issue_reg.mask;
   assign warp_pending  = ~fifo_empty | inflight;
   assign busy          = (|warp_pending) | issue_valid;

`ifdef WARP_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (issue_valid && issue_ready)
            perf_issued <= perf_issued + 32'd1;
         if (issue_valid && !issue_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
module tb_warp_scheduler;

   localparam int DEPTH = warp_pkg::FIFO_DEPTH;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_warp_id;
   logic [31:0] cmd_instr;
   logic [7:0]  cmd_mask;
   logic [3:0]  warp_enable;
   logic        issue_valid;
   logic        issue_ready;
   logic [1:0]  issue_warp_id;
   logic [31:0] issue_instr;
   logic [7:0]  issue_mask;
   logic        done_valid;
   logic [1:0]  done_warp_id;
   logic [3:0]  warp_pending;
   logic        busy;
   logic        err_orphan_done;
`ifdef WARP_SCHED_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
`endif

   warp_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_warp_id     (cmd_warp_id),
      .cmd_instr       (cmd_instr),
      .cmd_mask        (cmd_mask),
      .warp_enable     (warp_enable),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .issue_warp_id   (issue_warp_id),
      .issue_instr     (issue_instr),
      .issue_mask      (issue_mask),
      .done_valid      (done_valid),
      .done_warp_id    (done_warp_id),
      .warp_pending    (warp_pending),
      .busy            (busy),
`ifdef WARP_SCHED_PERF_EN
      .perf_issued     (perf_issued),
      .perf_stall      (perf_stall),
`endif
      .err_orphan_done (err_orphan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   logic [1:0]  rec_id    [$];
   logic [31:0] rec_instr [$];
   logic [7:0]  rec_mask  [$];

   typedef struct {
      logic        cv;
      logic [1:0]  cw;
      logic [31:0] ci;
      logic [7:0]  cm;
      logic        ir;
      logic        dv;
      logic [1:0]  dw;
      logic        ev;
      logic [1:0]  ewid;
      logic [31:0] einstr;
      logic [7:0]  emask;
      logic [3:0]  epend;
      logic        ebusy;
      logic        ecr;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid    = 1'b0;
      cmd_warp_id  = 2'd0;
      cmd_instr    = '0;
      cmd_mask     = '0;
      issue_ready  = 1'b1;
      done_valid   = 1'b0;
      done_warp_id = 2'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      warp_enable = 4'hF;
      #3;
      rst = 1'b0;
      step();
   endtask

   task automatic enq(input logic [1:0] w, input logic [31:0] ins, input logic [7:0] m);
      cmd_valid   = 1'b1;
      cmd_warp_id = w;
      cmd_instr   = ins;
      cmd_mask    = m;
      step();
      cmd_valid = 1'b0;
   endtask

   // Runs with issue_ready high, answering each handshake with a done one
   // cycle later, until busy drops; records every handshake in order.
   task automatic drain(input int max_cycles);
      logic       prev_hs = 1'b0;
      logic [1:0] prev_id = 2'd0;
      logic       hs_now;
      logic [1:0] cur_id;
      bit         timeout = 1'b1;
      issue_ready = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
         hs_now = issue_valid;
         cur_id = issue_warp_id;
         if (hs_now) begin
            rec_id.push_back(issue_warp_id);
            rec_instr.push_back(issue_instr);
            rec_mask.push_back(issue_mask);
         end
         done_valid   = prev_hs;
         done_warp_id = prev_id;
         step();
         prev_hs = hs_now;
         prev_id = cur_id;
      end
      done_valid = 1'b0;
      chk("drain_timeout", 32'(timeout), 32'd0);
   endtask

   initial begin
      logic [1:0]  exp_ord [6];
      logic [31:0] exp_ins [6];
      logic [7:0]  exp_msk [6];

      // cv cw ci cm ir dv dw | ev ewid einstr emask epend ebusy ecr
      vecs[0] = '{1'b1, 2'd2, 32'hA5A5_0001, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0100, 1'b1, 1'b1};
      vecs[1] = '{1'b0, 2'd2, 32'h0,         8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 32'hA5A5_0001, 8'hFF, 4'b0100, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 2'd2, 32'h0,         8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0100, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 2'd2, 32'h0,         8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 2'd0, 32'h0000_0042, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0001, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 2'd0, 32'h0,         8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 32'h0000_0042, 8'h00, 4'b0001, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 2'd0, 32'h0,         8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 32'h0000_0042, 8'h00, 4'b0001, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 2'd0, 32'h0,         8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0001, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 2'd0, 32'h0,         8'h00, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b1};

      // Reset values
      do_reset();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_wid", 32'(issue_warp_id), 32'd0);
      chk("rst_issue_instr", issue_instr, 32'd0);
      chk("rst_issue_mask", 32'(issue_mask), 32'd0);
      chk("rst_pending", 32'(warp_pending), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_orphan_done), 32'd0);
`ifdef WARP_SCHED_PERF_EN
      chk("rst_perf_issued", perf_issued, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
`endif

      // Table: single-warp latency, hold, completion, zero mask
      for (int i = 0; i < 9; i++) begin
         cmd_valid    = vecs[i].cv;
         cmd_warp_id  = vecs[i].cw;
         cmd_instr    = vecs[i].ci;
         cmd_mask     = vecs[i].cm;
         issue_ready  = vecs[i].ir;
         done_valid   = vecs[i].dv;
         done_warp_id = vecs[i].dw;
         step();
         cmd_valid  = 1'b0;
         done_valid = 1'b0;
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_pending", i), 32'(warp_pending), 32'(vecs[i].epend));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
         chk($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].ecr));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_wid", i), 32'(issue_warp_id), 32'(vecs[i].ewid));
            chk($sformatf("vec%0d_instr", i), issue_instr, vecs[i].einstr);
            chk($sformatf("vec%0d_mask", i), 32'(issue_mask), 32'(vecs[i].emask));
         end
      end
      chk("vec_err_clean", 32'(err_orphan_done), 32'd0);

      // Round robin across warps 0, 1, 3 with completion one cycle after issue
      do_reset();
      warp_enable = 4'h0;
      for (int k = 0; k < 2; k++) begin
         enq(2'd0, 32'h000 + 32'(k), 8'h01);
         enq(2'd1, 32'h100 + 32'(k), (k == 1) ? 8'h00 : 8'h02);
         enq(2'd3, 32'h300 + 32'(k), 8'h08);
      end
      chk("rr_pending", 32'(warp_pending), 32'b1011);
      chk("rr_disabled_no_issue", 32'(issue_valid), 32'd0);
      warp_enable = 4'hF;
      rec_id.delete(); rec_instr.delete(); rec_mask.delete();
      drain(60);
      exp_ord = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      exp_ins = '{32'h000, 32'h100, 32'h300, 32'h001, 32'h101, 32'h301};
      exp_msk = '{8'h01, 8'h02, 8'h08, 8'h01, 8'h00, 8'h08};
      chk("rr_count", 32'(rec_id.size()), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < rec_id.size()) begin
            chk($sformatf("rr_order%0d", k), 32'(rec_id[k]), 32'(exp_ord[k]));
            chk($sformatf("rr_instr%0d", k), rec_instr[k], exp_ins[k]);
            chk($sformatf("rr_mask%0d", k), 32'(rec_mask[k]), 32'(exp_msk[k]));
         end
      end
      chk("rr_err", 32'(err_orphan_done), 32'd0);

      // Full FIFO on warp 1, no bypass on a same-cycle pop
      do_reset();
      warp_enable = 4'h0;
      for (int k = 0; k < DEPTH; k++)
         enq(2'd1, 32'h10 + 32'(k), 8'h3C);
      cmd_warp_id = 2'd1;
      #1;
      chk("full_ready_w1", 32'(cmd_ready), 32'd0);
      cmd_warp_id = 2'd0;
      #1;
      chk("full_ready_w0", 32'(cmd_ready), 32'd1);
      warp_enable = 4'b0010;
      cmd_valid   = 1'b1;
      cmd_warp_id = 2'd1;
      cmd_instr   = 32'hDEAD;
      cmd_mask    = 8'hFF;
      step();
      cmd_valid = 1'b0;
      #1;
      chk("full_after_pop_ready", 32'(cmd_ready), 32'd1);
      chk("full_first_issue", issue_instr, 32'h10);
      warp_enable = 4'hF;
      rec_id.delete(); rec_instr.delete(); rec_mask.delete();
      drain(60);
      chk("full_no_bypass_count", 32'(rec_id.size()), 32'(DEPTH));
      for (int k = 0; k < DEPTH; k++)
         if (k < rec_instr.size())
            chk($sformatf("full_instr%0d", k), rec_instr[k], 32'h10 + 32'(k));
      cmd_warp_id = 2'd1;
      #1;
      chk("full_ready_end", 32'(cmd_ready), 32'd1);

      // Back-pressure hold
      do_reset();
      warp_enable = 4'h0;
      enq(2'd0, 32'hA0, 8'h11);
      enq(2'd1, 32'hB0, 8'h22);
      issue_ready = 1'b0;
      warp_enable = 4'hF;
      step();
      chk("hold_load_valid", 32'(issue_valid), 32'd1);
      chk("hold_load_wid", 32'(issue_warp_id), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("hold%0d_valid", k), 32'(issue_valid), 32'd1);
         chk($sformatf("hold%0d_wid", k), 32'(issue_warp_id), 32'd0);
         chk($sformatf("hold%0d_instr", k), issue_instr, 32'hA0);
         chk($sformatf("hold%0d_mask", k), 32'(issue_mask), 32'h11);
      end
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      chk("release_wid", 32'(issue_warp_id), 32'd1);
      chk("release_instr", issue_instr, 32'hB0);
`ifdef WARP_SCHED_PERF_EN
      chk("perf_stall", perf_stall, 32'd5);
      chk("perf_issued", perf_issued, 32'd1);
`endif

      // Orphan completion
      do_reset();
      done_valid   = 1'b1;
      done_warp_id = 2'd3;
      step();
      done_valid = 1'b0;
      chk("orphan_err", 32'(err_orphan_done), 32'd1);
      chk("orphan_pending", 32'(warp_pending), 32'd0);
      chk("orphan_valid", 32'(issue_valid), 32'd0);
      chk("orphan_busy", 32'(busy), 32'd0);
      step();
      step();
      chk("orphan_sticky", 32'(err_orphan_done), 32'd1);

      // Asynchronous reset mid-operation (err is still set from above)
      warp_enable = 4'h0;
      enq(2'd0, 32'hC0, 8'h01);
      enq(2'd0, 32'hC1, 8'h01);
      enq(2'd2, 32'hC2, 8'h04);
      issue_ready = 1'b0;
      warp_enable = 4'hF;
      step();
      chk("arst_pre_valid", 32'(issue_valid), 32'd1);
      chk("arst_pre_pending", 32'(warp_pending), 32'b0101);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(issue_valid), 32'd0);
      chk("arst_wid", 32'(issue_warp_id), 32'd0);
      chk("arst_instr", issue_instr, 32'd0);
      chk("arst_mask", 32'(issue_mask), 32'd0);
      chk("arst_pending", 32'(warp_pending), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_err", 32'(err_orphan_done), 32'd0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      #1;
      rst = 1'b0;
      issue_ready = 1'b1;
      step();
      step();
      chk("arst_after_busy", 32'(busy), 32'd0);
      chk("arst_after_valid", 32'(issue_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
